// File: rtl/prime_rf_pkg.sv
// Shared parameters and FSM state type for the prime-modulus register-file loader.
// The default word and address widths here are shared with the register file itself.
package prime_rf_pkg;

    localparam int PRIME_XLEN    = 33;
    localparam int PRIME_AR_BITS = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/prime_rf_loader_if.sv
// Prime stream (valid/ready) and register-file write port bundled for the loader.
// Handshake: a word transfers on a rising edge where s_valid && s_ready; the source
// holds s_data stable while s_valid is high, and s_ready never depends on s_valid.
interface prime_rf_loader_if
    import prime_rf_pkg::*;
#(
    parameter int XLEN    = PRIME_XLEN,
    parameter int AR_BITS = PRIME_AR_BITS
);

    logic               s_valid;
    logic               s_ready;
    logic [XLEN-1:0]    s_data;
    logic               rf_we;
    logic [AR_BITS-1:0] rf_dst;
    logic [XLEN-1:0]    rf_dstw;

    // Host / stream-source side.
    modport master (
        output s_valid, s_data,
        input  s_ready, rf_we, rf_dst, rf_dstw
    );

    // Loader side.
    modport slave (
        input  s_valid, s_data,
        output s_ready, rf_we, rf_dst, rf_dstw
    );

endinterface

// File: rtl/prime_rf_loader.sv
// Write-side sequencer: loads a stream of primes into consecutive register-file slots.
// Optional macro PRIME_LOAD_ODD_CHECK_EN drops even words and raises a sticky err flag.
module prime_rf_loader
    import prime_rf_pkg::*;
#(
    parameter int XLEN    = PRIME_XLEN,
    parameter int AR_BITS = PRIME_AR_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AR_BITS-1:0]   base_adr,
    input  logic [AR_BITS:0]     count,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output load_state_t          state,
    prime_rf_loader_if.slave     bus
);

    load_state_t        state_q, state_d;
    logic [AR_BITS-1:0] ptr_q;
    logic [AR_BITS:0]   rem_q;
    logic               rf_we_q;
    logic [AR_BITS-1:0] rf_dst_q;
    logic [XLEN-1:0]    rf_dstw_q;

    logic hs;
    logic last_word;
    logic word_ok;
    logic load_start;

    assign hs         = bus.s_valid && (state_q == ST_LOAD);
    assign last_word  = (rem_q == (AR_BITS+1)'(1));
    assign load_start = (state_q == ST_IDLE) && start;

`ifdef PRIME_LOAD_ODD_CHECK_EN
    // An even modulus is useless to the datapath, so its slot is skipped but still consumed.
    assign word_ok = bus.s_data[0];
`else
    assign word_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        bus.s_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = (count == '0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                busy        = 1'b1;
                bus.s_ready = 1'b1;
                if (hs && last_word) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // rf_dst/rf_dstw only change on a real write so an ungated file rewrites identical data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            rem_q     <= '0;
            rf_we_q   <= 1'b0;
            rf_dst_q  <= '0;
            rf_dstw_q <= '0;
        end else begin
            rf_we_q <= 1'b0;
            if (load_start) begin
                ptr_q <= base_adr;
                rem_q <= count;
            end
            if (hs) begin
                ptr_q <= ptr_q + AR_BITS'(1);
                rem_q <= rem_q - (AR_BITS+1)'(1);
                if (word_ok) begin
                    rf_we_q   <= 1'b1;
                    rf_dst_q  <= ptr_q;
                    rf_dstw_q <= bus.s_data;
                end
            end
        end
    end

`ifdef PRIME_LOAD_ODD_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                err_q <= 1'b0;
        else if (load_start)       err_q <= 1'b0;
        else if (hs && !word_ok)   err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign state       = state_q;
    assign bus.rf_we   = rf_we_q;
    assign bus.rf_dst  = rf_dst_q;
    assign bus.rf_dstw = rf_dstw_q;

endmodule

// File: tb/tb_prime_rf_loader.sv
// Directed-plus-random bench for prime_rf_loader with a register-file model and write scoreboard.
// Build with PRIME_LOAD_ODD_CHECK_EN defined to cover the even-word drop behaviour.
module tb_prime_rf_loader;
  import prime_rf_pkg::*;

  localparam int XLEN  = PRIME_XLEN;
  localparam int AR    = PRIME_AR_BITS;
  localparam int DEPTH = 1 << AR;
  localparam int W     = AR + XLEN;
`ifdef PRIME_LOAD_ODD_CHECK_EN
  localparam bit ODD_EN = 1'b1;
`else
  localparam bit ODD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AR-1:0] base_adr = '0;
  logic [AR:0]   count = '0;
  logic          busy, done, err;
  load_state_t   state;

  prime_rf_loader_if #(.XLEN(XLEN), .AR_BITS(AR)) bus ();

  prime_rf_loader #(.XLEN(XLEN), .AR_BITS(AR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_adr (base_adr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .state    (state),
    .bus      (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    obs_q[$];
  logic [XLEN-1:0] rf_mem[DEPTH];
  logic [XLEN-1:0] words[$];
  bit              exp_err;

  // Register file: writes on every edge, gated by rf_we.
  always @(posedge clk) begin
    if (bus.rf_we) begin
      rf_mem[bus.rf_dst] <= bus.rf_dstw;
      obs_q.push_back({bus.rf_dst, bus.rf_dstw});
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [AR-1:0] b, input logic [AR:0] c);
    base_adr = b;
    count    = c;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    base_adr = AR'($urandom);
    count    = (AR+1)'($urandom);
    check("start_busy", busy, 1);
    check("start_ready", bus.s_ready, (c != 0));
    check("start_done", done, (c == 0));
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(XLEN'({$urandom, $urandom}) | XLEN'(1));
  endtask

  // Streams the whole words queue into an active load; model: slot k goes to (b + k) mod DEPTH.
  task automatic stream(input logic [AR-1:0] b, input int gap_pct);
    int n = words.size();
    int sent = 0;
    int cyc = 0;
    bit hs;
    bit wr;
    logic [AR-1:0] adr;
    exp_err = 1'b0;
    while (sent < n && cyc < 4000) begin
      bus.s_valid = ($urandom_range(99) >= gap_pct);
      bus.s_data  = bus.s_valid ? words[sent] : XLEN'({$urandom, $urandom});
      check("ready_in_load", bus.s_ready, 1);
      hs  = bus.s_valid;
      wr  = 1'b0;
      adr = '0;
      @(negedge clk);
      cyc++;
      if (hs) begin
        adr = b + AR'(sent);
        wr  = !ODD_EN || words[sent][0];
        if (!wr) exp_err = 1'b1;
        if (wr) exp_q.push_back({adr, words[sent]});
        sent++;
      end
      check("rf_we", bus.rf_we, hs && wr);
      if (hs && wr) begin
        check("rf_dst", bus.rf_dst, adr);
        check("rf_dstw", bus.rf_dstw, words[sent-1]);
      end
      check("done_pulse", done, hs && (sent == n));
      check("busy_in_load", busy, 1);
    end
    bus.s_valid = 1'b0;
    if (sent < n) check("stream_timeout", sent, n);
    @(negedge clk);
    check("end_state", state, ST_IDLE);
    check("end_busy", busy, 0);
    check("end_done", done, 0);
    check("end_rf_we", bus.rf_we, 0);
    check("end_err", err, exp_err);
  endtask

  task automatic verify(input logic [AR-1:0] b);
    logic [W-1:0] got;
    logic [AR-1:0] a;
    check("write_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      check("write_seq", got, exp_q.pop_front());
    end
    for (int i = 0; i < words.size(); i++) begin
      a = b + AR'(i);
      if (!ODD_EN || words[i][0]) check("readback", rf_mem[a], words[i]);
    end
    obs_q.delete();
  endtask

  task automatic load(input logic [AR-1:0] b, input int gap_pct);
    do_start(b, (AR+1)'(words.size()));
    stream(b, gap_pct);
    verify(b);
  endtask

  // ---------------- directed sequence ----------------
  logic [AR-1:0] rb;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    @(negedge clk);
    check("rst_state", state, ST_IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", bus.s_ready, 0);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_dst", bus.rf_dst, 0);
    check("rst_rf_dstw", bus.rf_dstw, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stream words offered while idle are ignored.
    bus.s_valid = 1'b1;
    bus.s_data  = XLEN'(33'h1_2345_6789);
    repeat (2) begin
      @(negedge clk);
      check("idle_ready", bus.s_ready, 0);
      check("idle_rf_we", bus.rf_we, 0);
    end
    bus.s_valid = 1'b0;
    check("idle_no_write", obs_q.size(), 0);

    // Basic four-word load at base 5.
    words.delete();
    words.push_back(XLEN'(8'h11));
    words.push_back(XLEN'(8'h13));
    words.push_back(XLEN'(8'h17));
    words.push_back(XLEN'(8'h1D));
    load(AR'(5), 0);

    // Pointer wrap at the top of the file.
    fill_random(3);
    load(AR'(62), 0);

    // Random valid gaps over a ten-word load.
    fill_random(10);
    rb = AR'($urandom);
    load(rb, 40);

    // Zero-length load.
    do_start(AR'(7), '0);
    check("zero_rf_we", bus.rf_we, 0);
    @(negedge clk);
    check("zero_state", state, ST_IDLE);
    check("zero_busy", busy, 0);
    check("zero_done", done, 0);
    check("zero_writes", obs_q.size(), 0);

    // A second start during LOAD must be ignored.
    fill_random(3);
    do_start(AR'(20), 3);
    base_adr = AR'(40);
    count    = '0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    check("restart_ready", bus.s_ready, 1);
    stream(AR'(20), 0);
    verify(AR'(20));

    // Whole-file load.
    fill_random(DEPTH);
    rb = AR'($urandom);
    load(rb, 10);

    // Even word in the middle of the stream.
    words.delete();
    words.push_back(XLEN'(8'h11));
    words.push_back(XLEN'(8'h10));
    words.push_back(XLEN'(8'h13));
    load(AR'(0), 0);
    check("odd_err_sticky", err, ODD_EN);
    do_start(AR'(3), '0);
    check("err_cleared", err, 0);
    @(negedge clk);

    // Reset after the second of five handshakes.
    fill_random(5);
    do_start(AR'(10), 5);
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = words[i];
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_state", state, ST_IDLE);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_ready", bus.s_ready, 0);
    check("abort_rf_we", bus.rf_we, 0);
    check("abort_rf_dst", bus.rf_dst, 0);
    check("abort_rf_dstw", bus.rf_dstw, 0);
    check("abort_kept_write", rf_mem[10], words[0]);
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    fill_random(2);
    load(AR'(0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time bound so the bench can never hang.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prime_rf_loader.md
# prime_rf_loader

Write-side sequencer for the prime-modulus register file. It accepts a stream of XLEN-bit primes over a valid/ready handshake and writes them into consecutive register-file addresses from a programmed base. The register file's write port is `rf_dst`/`rf_dstw`. This block sits between the host/DMA prime stream and that port, and the compute datapath reads prime pairs from the other side.

## Interface
- `XLEN`, default 33: prime word width, equal to the register-file word width.
- `AR_BITS`, default 6: register-file address width.
- `clk` in, 1: single clock; all state updates on its rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: begin a load; sampled only in IDLE.
- `base_adr` in, AR_BITS: first destination address; captured on `start`.
- `count` in, AR_BITS+1: number of primes to load, 0..2^AR_BITS; captured on `start`.
- `busy` out, 1: high in LOAD and DONE.
- `done` out, 1: one-cycle pulse at the end of a load.
- `err` out, 1: sticky rejected-word flag; always 0 without the macro.
- `s_valid` in, 1: stream word valid.
- `s_ready` out, 1: loader can accept a word.
- `s_data` in, XLEN: stream word.
- `rf_we` out, 1: write strobe to the register file.
- `rf_dst` out, AR_BITS: write address.
- `rf_dstw` out, XLEN: write data.

## Operation
- FSM states are IDLE, LOAD and DONE.
- **IDLE**
  - `s_ready`=0.
  - On `start`=1: capture `base_adr` into the pointer, `count` into the remaining counter, and clear `err`.
  - If `count`==0, go to DONE; otherwise go to LOAD.
- **LOAD**
  - `s_ready`=1, decoded from the state register (not combinational on `s_valid`).
  - A handshake is `s_valid`&&`s_ready`. On each handshake:
    - register `rf_dst`=pointer, `rf_dstw`=`s_data` and `rf_we`=1 for the following cycle;
    - increment the pointer modulo 2^AR_BITS (wrap 63→0 at default);
    - decrement the remaining counter.
  - The handshake that brings the remaining counter to 0 moves the FSM to DONE.
- **DONE**
  - `done`=1 for exactly this one cycle, then return to IDLE.
- `start` outside IDLE is ignored.
- `s_data` is ignored whenever `s_ready`=0.
- The register file writes on every clock edge. Integration gates its write with `rf_we`.
  - When `rf_we`=0, `rf_dst` and `rf_dstw` hold their last values, so an ungated instance rewrites identical data.
- Pointer arithmetic is AR_BITS wide with no carry-out. `count`=2^AR_BITS fills the whole file once.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `s_ready`, `rf_we` = 0; `rf_dst`, `rf_dstw` = 0.
- Reset mid-load aborts the load immediately. Writes already issued stay in the register file.
- `start` sampled at cycle 0 → `busy`=1 and `s_ready`=1 at cycle 1.
- Handshake at cycle t → `rf_we`=1 with that word at cycle t+1. Write latency is 1 cycle.
- Back-to-back handshakes give one write per cycle (full throughput).
- Last handshake at t → DONE at t+1, with `done`=1 concurrent with the final `rf_we`.
  - IDLE at t+2; a new `start` is accepted at t+2.
- `count`=0: `start` at cycle 0 → `done` at cycle 1, IDLE at cycle 2, no writes.
- `s_valid` gaps stall the load indefinitely with no timeout. No write is issued in stall cycles.

## Configuration
- Macro: `PRIME_LOAD_ODD_CHECK_EN`.
- **Defined:** an accepted word with `s_data[0]`==0 (even, so not a usable prime modulus) is not written.
  - `rf_we` stays 0 for that slot.
  - The pointer and remaining counter still advance, so later words land at their intended addresses.
  - `err` sets and stays set until the next accepted `start`.
- **Undefined:** every accepted word is written and `err` is tied 0.

## Structure
- Package `prime_rf_pkg` holds:
  - default `XLEN`/`AR_BITS` localparams, shared with the register file;
  - the FSM state enum typedef `load_state_t`.
- No sub-module: a single flat module with the FSM, pointer, counter and output registers.

## Test plan
- Load 4 words (0x11, 0x13, 0x17, 0x1D) with `base_adr`=5 and continuous `s_valid` → `rf_we` on 4 consecutive cycles at addresses 5, 6, 7, 8. `done` pulses with the address-8 write, and the register file reads back the values.
- `base_adr`=62, `count`=3 → writes at 62, 63, 0 (wrap).
- Random `s_valid` gaps over a 10-word load → exactly 10 writes, in order, with no write during gaps.
- `count`=0 → `done` one cycle after `start`, zero writes. A second `start` issued while busy is ignored.
- Assert `rst_n` low after the 2nd of 5 handshakes → all outputs 0 and IDLE. After release, a fresh load of 2 words to base 0 succeeds.
- With `PRIME_LOAD_ODD_CHECK_EN`, stream 0x11, 0x10, 0x13 from base 0 → writes at 0 and 2 only, and `err`=1.
  - `err` clears on the next `start`.
